// File: rtl/pic_ack_sequencer.sv
// pic_ack_sequencer: CPU-side command sequencer for the PIC priority block.
// Runs the two-step INTA acknowledge, hands the vector to the CPU, sends EOI/init.
module pic_ack_sequencer #(
  parameter logic [4:0]  VEC_BASE = 5'b00001,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned ACK_HOLD = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] PRIORITY_MODE,
  input  logic [7:0] PRIORITY_DATA,
  output logic [2:0] CU_MODE,
  output logic [7:0] CU_DATA,
  output logic       CU_WRITE,
  input  logic       CPU_INIT,
  input  logic       CPU_AEOI,
  input  logic       CPU_LTIM,
  output logic [7:0] CPU_VEC,
  output logic       CPU_VEC_VALID,
  input  logic       CPU_VEC_READY,
  input  logic       CPU_EOI,
  output logic       BUSY,
  output logic       ERR
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_INIT     = 4'd1;
  localparam logic [3:0] S_ACK1     = 4'd2;
  localparam logic [3:0] S_GAP      = 4'd3;
  localparam logic [3:0] S_ACK2     = 4'd4;
  localparam logic [3:0] S_WAIT_VEC = 4'd5;
  localparam logic [3:0] S_PRESENT  = 4'd6;
  localparam logic [3:0] S_WAIT_EOI = 4'd7;
  localparam logic [3:0] S_SEND_EOI = 4'd8;
  localparam logic [3:0] S_NEUTRAL  = 4'd9;

  localparam logic [2:0] M_NEUTRAL = 3'b101;
  localparam logic [2:0] M_INIT    = 3'b100;
  localparam logic [2:0] M_ACK     = 3'b110;
  localparam logic [2:0] M_OCW2    = 3'b011;
  localparam logic [2:0] M_PEND    = 3'b110;
  localparam logic [2:0] M_HANDLE  = 3'b101;

  localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] H_LAST = 4'(ACK_HOLD - 1);

  logic [2:0] mode_s1;
  logic [2:0] mode_s2;
  logic [2:0] lvl_s1;
  logic [2:0] lvl_s2;
  logic       pend_q;
  logic       pend_now;
  logic       pend_edge;
  logic       handling;
  logic       pending;
  logic       take_ack;
  logic [2:0] req_level;
  logic [3:0] state;
  logic [3:0] hold_cnt;
  logic [7:0] timer;
  logic       cfg_ltim;
  logic       cfg_aeoi;
  logic       unused_bits;

  assign unused_bits = ^PRIORITY_DATA[7:3];

  assign pend_now  = (mode_s2 == M_PEND);
  assign pend_edge = pend_now & ~pend_q;
  assign handling  = (mode_s2 == M_HANDLE);
  assign take_ack  = (state == S_IDLE) & ~CPU_INIT & pending;
  assign BUSY      = (state != S_IDLE);

  // Two-flop synchroniser for the asynchronous PIC status lines.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_s1 <= 3'd0;
      mode_s2 <= 3'd0;
      lvl_s1  <= 3'd0;
      lvl_s2  <= 3'd0;
    end else begin
      mode_s1 <= PRIORITY_MODE;
      mode_s2 <= mode_s1;
      lvl_s1  <= PRIORITY_DATA[2:0];
      lvl_s2  <= lvl_s1;
    end
  end

  // Sticky pending request; a fresh edge wins over the clear on ACK start.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q    <= 1'b0;
      pending   <= 1'b0;
      req_level <= 3'd0;
    end else begin
      pend_q <= pend_now;
      if (pend_edge) begin
        pending   <= 1'b1;
        req_level <= lvl_s2;
      end else if (take_ack) begin
        pending <= 1'b0;
      end
    end
  end

  // Sequencer FSM with the CPU-facing vector/error registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= S_IDLE;
      hold_cnt      <= 4'd0;
      timer         <= 8'd0;
      CPU_VEC       <= 8'd0;
      CPU_VEC_VALID <= 1'b0;
      ERR           <= 1'b0;
      cfg_ltim      <= 1'b0;
      cfg_aeoi      <= 1'b0;
    end else begin
      ERR <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (CPU_INIT) begin
            cfg_ltim <= CPU_LTIM;
            cfg_aeoi <= CPU_AEOI;
            state    <= S_INIT;
          end else if (pending) begin
            hold_cnt <= 4'd0;
            state    <= S_ACK1;
          end
        end
        S_INIT: state <= S_NEUTRAL;
        S_ACK1: begin
          if (hold_cnt == H_LAST) begin
            hold_cnt <= 4'd0;
            state    <= S_GAP;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        S_GAP: state <= S_ACK2;
        S_ACK2: begin
          if (hold_cnt == H_LAST) begin
            hold_cnt <= 4'd0;
            timer    <= 8'd0;
            state    <= S_WAIT_VEC;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        S_WAIT_VEC: begin
          if (handling) begin
            cfg_aeoi      <= CPU_AEOI;
            CPU_VEC       <= {VEC_BASE, lvl_s2};
            CPU_VEC_VALID <= 1'b1;
            ERR           <= (lvl_s2 != req_level);
            state         <= S_PRESENT;
          end else if (timer == T_LAST) begin
            ERR   <= 1'b1;
            state <= S_NEUTRAL;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        S_PRESENT: begin
          if (CPU_VEC_READY) begin
            CPU_VEC_VALID <= 1'b0;
            state <= cfg_aeoi ? S_IDLE : S_WAIT_EOI;
          end
        end
        S_WAIT_EOI: begin
          if (CPU_EOI) state <= S_SEND_EOI;
        end
        S_SEND_EOI: state <= S_NEUTRAL;
        S_NEUTRAL:  state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  // Command bus decode: neutral unless a command state is active.
  always_comb begin
    CU_MODE  = M_NEUTRAL;
    CU_DATA  = 8'd0;
    CU_WRITE = 1'b0;
    unique case (state)
      S_INIT: begin
        CU_MODE  = M_INIT;
        CU_DATA  = {6'b0, cfg_ltim, cfg_aeoi};
        CU_WRITE = 1'b1;
      end
      S_ACK1, S_ACK2: begin
        CU_MODE  = M_ACK;
        CU_WRITE = (hold_cnt == 4'd0);
      end
      S_SEND_EOI: begin
        CU_MODE  = M_OCW2;
        CU_DATA  = 8'h20;
        CU_WRITE = 1'b1;
      end
      default: begin
        CU_MODE  = M_NEUTRAL;
        CU_DATA  = 8'd0;
        CU_WRITE = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// tb_pic_ack_sequencer: scoreboard bench for pic_ack_sequencer.
// Drivers queue expected commands/vectors/errors; a negedge monitor checks them.
module tb_pic_ack_sequencer;

  localparam logic [4:0] VB = 5'b00001;
  localparam int TO = 16;
  localparam int AH = 2;

  typedef struct packed {
    logic [2:0] mode;
    logic [7:0] data;
  } cmd_t;

  typedef struct packed {
    logic [7:0] vec;
    logic       aeoi;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] pmode;
  logic [7:0] pdata;
  logic [2:0] cu_mode;
  logic [7:0] cu_data;
  logic       cu_write;
  logic       init;
  logic       aeoi;
  logic       ltim;
  logic [7:0] vec;
  logic       valid;
  logic       ready;
  logic       eoi;
  logic       busy;
  logic       err;

  cmd_t cmd_q[$];
  vec_t vec_q[$];
  int   err_q = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int last_wr_cyc = 0;
  int prev_wr_cyc = 0;
  int err_seen = 0;
  int last_err_cyc = 0;
  int hs_cyc = 0;
  int wr_after_hs = 0;
  int ack_base = 0;
  int ack1_cyc = 0;
  int ack2_cyc = 0;
  int drv_cyc = 0;

  logic       prev_wr = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_vec = 8'd0;
  logic       post_hs = 1'b0;
  logic       exp_busy = 1'b0;
  logic       hs_armed = 1'b0;
  int         bcd = 0;

  pic_ack_sequencer #(
    .VEC_BASE(VB),
    .TIMEOUT (TO),
    .ACK_HOLD(AH)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .PRIORITY_MODE(pmode),
    .PRIORITY_DATA(pdata),
    .CU_MODE      (cu_mode),
    .CU_DATA      (cu_data),
    .CU_WRITE     (cu_write),
    .CPU_INIT     (init),
    .CPU_AEOI     (aeoi),
    .CPU_LTIM     (ltim),
    .CPU_VEC      (vec),
    .CPU_VEC_VALID(valid),
    .CPU_VEC_READY(ready),
    .CPU_EOI      (eoi),
    .BUSY         (busy),
    .ERR          (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    if (rst) begin
      prev_wr    = 1'b0;
      prev_valid = 1'b0;
      post_hs    = 1'b0;
      hs_armed   = 1'b0;
      bcd        = 0;
    end else begin
      if (bcd > 0) begin
        bcd--;
        if (bcd == 0) check("busy_after_cmd", {15'd0, busy}, 16'd0);
      end
      if (cu_write && prev_wr) check("write_back_to_back", 16'd1, 16'd0);
      if (!cu_write)
        check("neutral_bus",
              {15'd0, (cu_mode == 3'b110 && cu_data == 8'd0) ||
                      (cu_mode == 3'b101 && cu_data == 8'd0)}, 16'd1);
      if (cu_write) begin
        cmd_t e;
        wr_count++;
        prev_wr_cyc = last_wr_cyc;
        last_wr_cyc = cyc;
        if (hs_armed) begin
          wr_after_hs = cyc;
          hs_armed = 1'b0;
        end
        check("cmd_expected", {15'd0, cmd_q.size() != 0}, 16'd1);
        if (cmd_q.size() != 0) begin
          e = cmd_q.pop_front();
          check("cmd_mode", {13'd0, cu_mode}, {13'd0, e.mode});
          check("cmd_data", {8'd0, cu_data}, {8'd0, e.data});
          if (e.mode != 3'b110) bcd = 2;
        end
      end
      if (post_hs) begin
        post_hs = 1'b0;
        check("valid_drop", {15'd0, valid}, 16'd0);
        check("busy_after_hs", {15'd0, busy}, {15'd0, exp_busy});
      end
      if (valid && !prev_valid) begin
        check("vec_expected", {15'd0, vec_q.size() != 0}, 16'd1);
        if (vec_q.size() != 0)
          check("vec_value", {8'd0, vec}, {8'd0, vec_q[0].vec});
      end
      if (valid && prev_valid)
        check("vec_stable", {8'd0, vec}, {8'd0, prev_vec});
      if (valid && ready && vec_q.size() != 0) begin
        exp_busy = !vec_q[0].aeoi;
        void'(vec_q.pop_front());
        post_hs  = 1'b1;
        hs_armed = 1'b1;
        hs_cyc   = cyc;
      end
      if (err) begin
        err_seen++;
        last_err_cyc = cyc;
        check("err_expected", {15'd0, err_q > 0}, 16'd1);
        if (err_q > 0) err_q--;
      end
      prev_wr    = cu_write;
      prev_valid = valid;
      prev_vec   = vec;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] m, input logic [7:0] d);
    cmd_t c;
    c.mode = m;
    c.data = d;
    cmd_q.push_back(c);
  endtask

  task automatic wait_wr(input int target, input string name);
    int n;
    n = 0;
    while (wr_count < target && n < 300) begin
      tick();
      n++;
    end
    check(name, {15'd0, wr_count >= target}, 16'd1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!valid && n < 300) begin
      tick();
      n++;
    end
    check("wait_valid", {15'd0, valid}, 16'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check("wait_idle", {15'd0, busy}, 16'd0);
  endtask

  task automatic raise_request(input logic [2:0] lvl);
    ack_base = wr_count;
    push_cmd(3'b110, 8'h00);
    push_cmd(3'b110, 8'h00);
    pmode   = 3'b110;
    pdata   = {5'd0, lvl};
    drv_cyc = cyc;
  endtask

  task automatic service(input logic [2:0] lvl, input logic [2:0] hl,
                         input logic ae, input int rdly, input bit pre,
                         input bit qnext, input logic [2:0] nl);
    vec_t v;
    if (!pre) raise_request(lvl);
    wait_wr(ack_base + 2, "ack_writes");
    ack1_cyc = prev_wr_cyc;
    ack2_cyc = last_wr_cyc;
    aeoi  = ae;
    pmode = 3'b101;
    pdata = {5'd0, hl};
    v.vec  = 8'(int'(VB) * 8 + int'(hl));
    v.aeoi = ae;
    vec_q.push_back(v);
    if (hl != lvl) err_q++;
    wait_valid();
    if (qnext) raise_request(nl);
    else pmode = 3'b000;
    repeat (rdly) tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    if (!ae) begin
      push_cmd(3'b011, 8'h20);
      repeat ($urandom_range(0, 3)) tick();
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
    end
    repeat (3) tick();
  endtask

  task automatic timeout_run(input logic [2:0] lvl);
    int base_err;
    int n;
    base_err = err_seen;
    n = 0;
    raise_request(lvl);
    err_q++;
    wait_wr(ack_base + 2, "to_ack_writes");
    ack2_cyc = last_wr_cyc;
    while (err_seen == base_err && n < 300) begin
      tick();
      n++;
    end
    check("timeout_err_count", 16'(err_seen - base_err), 16'd1);
    check("timeout_latency", 16'(last_err_cyc - ack2_cyc), 16'(AH + TO));
    check("timeout_idle", {15'd0, busy}, 16'd0);
    pmode = 3'b000;
    repeat (3) tick();
  endtask

  task automatic init_run(input logic lt, input logic ae);
    wait_idle();
    ltim = lt;
    aeoi = ae;
    init = 1'b1;
    push_cmd(3'b100, {6'd0, lt, ae});
    tick();
    init = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before;
    int sel;
    logic [2:0] l;
    logic [2:0] h;
    rst = 1'b1;
    pmode = 3'b000;
    pdata = 8'd0;
    init = 1'b0;
    aeoi = 1'b0;
    ltim = 1'b0;
    ready = 1'b0;
    eoi = 1'b0;
    #2;
    check("rst_cu_mode", {13'd0, cu_mode}, 16'h0005);
    check("rst_cu_data", {8'd0, cu_data}, 16'd0);
    check("rst_cu_write", {15'd0, cu_write}, 16'd0);
    check("rst_vec", {8'd0, vec}, 16'd0);
    check("rst_valid", {15'd0, valid}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_err", {15'd0, err}, 16'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    init_run(1'b1, 1'b0);

    service(3'd3, 3'd3, 1'b0, 3, 1'b0, 1'b0, 3'd0);
    check("ack1_latency", 16'(ack1_cyc - drv_cyc), 16'd4);
    check("ack2_latency", 16'(ack2_cyc - drv_cyc), 16'd7);

    service(3'd3, 3'd3, 1'b1, 3, 1'b0, 1'b0, 3'd0);

    timeout_run(3'd5);

    service(3'd2, 3'd4, 1'b1, 5, 1'b0, 1'b1, 3'd6);
    wait_wr(ack_base + 1, "queued_ack");
    check("queued_ack_delay", 16'(wr_after_hs - hs_cyc), 16'd2);
    service(3'd6, 3'd6, 1'b0, 2, 1'b1, 1'b0, 3'd0);

    raise_request(3'd1);
    wait_wr(ack_base + 2, "rst_ack_writes");
    #2;
    rst = 1'b1;
    pmode = 3'b000;
    #1;
    check("mid_rst_cu_mode", {13'd0, cu_mode}, 16'h0005);
    check("mid_rst_cu_data", {8'd0, cu_data}, 16'd0);
    check("mid_rst_cu_write", {15'd0, cu_write}, 16'd0);
    check("mid_rst_valid", {15'd0, valid}, 16'd0);
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_err", {15'd0, err}, 16'd0);
    repeat (3) tick();
    rst = 1'b0;
    wr_before = wr_count;
    repeat (8) tick();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    repeat (8) tick();
    check("post_rst_idle", {15'd0, busy}, 16'd0);
    check("post_rst_no_cmd", 16'(wr_count - wr_before), 16'd0);
    service(3'd7, 3'd7, 1'b0, 1, 1'b0, 1'b0, 3'd0);

    for (int k = 0; k < 25; k++) begin
      sel = $urandom_range(0, 9);
      l = 3'($urandom_range(0, 7));
      h = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : l;
      if (sel == 0)
        init_run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (sel == 1)
        timeout_run(l);
      else
        service(l, h, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                1'b0, 1'b0, 3'd0);
    end

    wait_idle();
    repeat (10) tick();
    check("cmd_q_empty", 16'(cmd_q.size()), 16'd0);
    check("vec_q_empty", 16'(vec_q.size()), 16'd0);
    check("err_q_empty", 16'(err_q), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pic_ack_sequencer.md
Name: pic_ack_sequencer

Overview:
- Initiator-side controller that drives the PIC priority block's command interface (CU_MODE/CU_DATA/CU_WRITE) on behalf of the CPU.
- Detects a pending-interrupt indication, runs the two-step INTA acknowledge, and captures the serviced IR level. It then presents an 8-bit vector to the CPU with a valid/ready handshake and issues the non-specific EOI (OCW2) when the CPU requests it.
- Also issues the initialisation command word on CPU request.

Parameters:
- VEC_BASE, 5'b00001, upper 5 bits of the vector; vector = {VEC_BASE, level[2:0]}.
- TIMEOUT, 16, cycles to wait for the PIC handling response before aborting; range 2..255.
- ACK_HOLD, 2, cycles each ACK command is held on CU_MODE; range 1..15.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- PRIORITY_MODE  in  3  PIC status mode: 110 = pending (data = level), 101 = handling (data = level). Asynchronous to CLK.
- PRIORITY_DATA  in  8  PIC status data; only bits [2:0] are used.
- CU_MODE  out  3  command mode to the PIC.
- CU_DATA  out  8  command data to the PIC.
- CU_WRITE  out  1  one-cycle command strobe.
- CPU_INIT  in  1  one-cycle request to send the init command.
- CPU_AEOI  in  1  AEOI config; sampled on CPU_INIT and on each vector capture.
- CPU_LTIM  in  1  1 = level triggered; sent on init.
- CPU_VEC  out  8  interrupt vector.
- CPU_VEC_VALID  out  1  vector valid.
- CPU_VEC_READY  in  1  CPU accepts the vector.
- CPU_EOI  in  1  one-cycle EOI request.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  one-cycle pulse on timeout or level mismatch.

Behaviour:
- Reset values (RST high, effective immediately and mid-operation): CU_MODE=3'b101 (neutral), CU_DATA=0, CU_WRITE=0, CPU_VEC=0, CPU_VEC_VALID=0, BUSY=0, ERR=0, state=IDLE, pending=0, timers=0.
- Synchroniser: PRIORITY_MODE and PRIORITY_DATA[2:0] pass through 2 flops.
- pend_edge: rising edge of the synchronised (mode==110) condition. It is detected in all states and sets a sticky pending flag with latched req_level. A later edge overwrites req_level.
- Neutral output: CU_MODE=101, CU_DATA=0, CU_WRITE=0 whenever no command is being driven.
- States:
  - IDLE: CPU_INIT has priority over pending → INIT. Otherwise pending → ACK1, which clears pending.
  - INIT: 1 cycle; CU_MODE=100, CU_DATA={6'b0,CPU_LTIM,CPU_AEOI}, CU_WRITE=1 → NEUTRAL.
  - ACK1: CU_MODE=110 for ACK_HOLD cycles; CU_WRITE=1 in the first cycle only → GAP.
  - GAP: 1 cycle neutral, so the second ACK is a fresh CU_MODE change → ACK2.
  - ACK2: same as ACK1 → WAIT_VEC. The timer loads 0.
  - WAIT_VEC: neutral outputs.
    - Synchronised mode==101 → capture level. If level != req_level, pulse ERR but still use the captured level. Set CPU_VEC={VEC_BASE,level} and CPU_VEC_VALID=1 → PRESENT.
    - Timer reaching TIMEOUT-1 → pulse ERR → NEUTRAL; no vector is presented.
  - PRESENT: CPU_VEC and CPU_VEC_VALID are held stable until CPU_VEC_READY is sampled high. On that cycle, drop VALID the next cycle → IDLE if the AEOI latched at capture=1, else WAIT_EOI.
  - WAIT_EOI: on CPU_EOI → SEND_EOI.
  - SEND_EOI: 1 cycle; CU_MODE=011, CU_DATA=8'h20, CU_WRITE=1 → NEUTRAL.
  - NEUTRAL: 1 cycle neutral → IDLE.
- CPU_EOI outside WAIT_EOI is ignored. CPU_INIT outside IDLE is ignored (not queued).
- Latency:
  - PRIORITY_MODE→110 stable to first CU_WRITE: 4 rising edges (2 sync, 1 edge-detect/pending, 1 state).
  - ACK1 CU_WRITE to ACK2 CU_WRITE: ACK_HOLD+1 cycles.
- A pend_edge arriving during service is retained and served after return to IDLE.
- CU_WRITE is never high two consecutive cycles. Consecutive commands are always separated by ≥1 neutral cycle.

Test Plan:
- Init: CPU_INIT pulse, LTIM=1, AEOI=0 → one cycle CU_MODE=100, CU_DATA=8'h02, CU_WRITE=1; then CU_MODE=101.
- Normal manual-EOI service, VEC_BASE=5'b00001:
  - Stimulus: PRIORITY_MODE=110/data=3 held; after ACK2, PRIORITY_MODE=101/data=3; READY after 3 cycles; then CPU_EOI.
  - Response: CU_MODE=110 pulses with CU_WRITE at edges 4 and 7 (ACK_HOLD=2), separated by 1 neutral cycle. CPU_VEC=8'h0B, VALID held 3 cycles. Then one OCW2 cycle (011, 8'h20, CU_WRITE=1) and BUSY low 2 cycles later.
- AEOI: same stimulus with AEOI=1 sampled at capture → no OCW2 issued; BUSY low 1 cycle after the READY handshake.
- Timeout: mode=110/data=5, never 101 → ERR pulses exactly once TIMEOUT cycles after entering WAIT_VEC; CPU_VEC_VALID never asserts; state returns to IDLE.
- Mismatch and queued request:
  - Pending level 2 but handling data=4 → ERR pulse and CPU_VEC={VEC_BASE,3'd4}.
  - A second 110 edge during PRESENT → a new ACK1 starts on the 2nd cycle after IDLE is reached.
- Reset mid-ACK2 (RST high asynchronously between clock edges) → outputs return to reset values immediately. After release, no command is issued until a new 110 edge arrives; CPU_EOI in IDLE is ignored.
